// File: rtl/psg_pkg.sv
// rtl/psg_pkg.sv - shared sequencer states, request payload and BDIR/BC bus-mode encodings
package psg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP_A,
    S_WRITE,
    S_READ,
    S_GAP_D
  } psg_bus_state_t;

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } psg_req_t;

  // {BDIR, BC} pairs
  localparam logic [1:0] INACTIVE = 2'b00;
  localparam logic [1:0] READ     = 2'b01;
  localparam logic [1:0] WRITE    = 2'b10;
  localparam logic [1:0] LATCH    = 2'b11;

endpackage

// File: rtl/psg_req_fifo.sv
// rtl/psg_req_fifo.sv - power-of-2 request queue with full/empty flags and fill count
module psg_req_fifo
  import psg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  psg_req_t      push_data,
  input  logic          pop,
  output psg_req_t      pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = CW - 1;

  psg_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

  // pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/psg_bus_master.sv
// rtl/psg_bus_master.sv - queued YM2149 BDIR/BC bus initiator; PSG_BUS_ADDR_CACHE_EN skips repeated address phases
module psg_bus_master
  import psg_pkg::*;
#(
  parameter int PHASE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WR,
  input  logic [3:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] PSG_DO,
  input  logic [7:0] PSG_DI
);

  localparam logic [3:0] PHASE_LOAD = 4'(PHASE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);
  localparam int         CW         = $clog2(FIFO_DEPTH) + 1;

  psg_bus_state_t state, state_next;
  logic [3:0]     cnt, cnt_next;
  psg_req_t       cur, head, in_req;
  logic           full, empty, push, pop, cache_hit, read_last;
  logic [CW-1:0]  fill, fill_next;
  logic [1:0]     mode;

  assign in_req    = '{wr: REQ_WR, addr: REQ_ADDR, data: REQ_DATA};
  assign push      = REQ_VALID && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign REQ_READY = !full;
  assign fill_next = fill + CW'(push) - CW'(pop);
  assign read_last = (state == S_READ) && (cnt == 4'd0);
  assign {BDIR, BC} = mode;

  psg_req_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (push),
    .push_data (in_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fill)
  );

`ifdef PSG_BUS_ADDR_CACHE_EN
  logic [3:0] last_addr;
  logic       last_valid;

  // the PSG keeps its latched register number, so a repeat address needs no new latch phase
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_addr  <= 4'h0;
      last_valid <= 1'b0;
    end else if (state == S_ADDR && cnt == 4'd0) begin
      last_addr  <= cur.addr;
      last_valid <= 1'b1;
    end
  end

  assign cache_hit = last_valid && (head.addr == last_addr);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt - 4'd1;
    mode       = INACTIVE;
    PSG_DO     = 8'hFF;
    case (state)
      S_IDLE: begin
        cnt_next = PHASE_LOAD;
        if (!empty) state_next = cache_hit ? (head.wr ? S_WRITE : S_READ) : S_ADDR;
      end
      S_ADDR: begin
        mode   = LATCH;
        PSG_DO = {4'h0, cur.addr};
        if (cnt == 4'd0) begin
          state_next = S_GAP_A;
          cnt_next   = GAP_LOAD;
        end
      end
      S_GAP_A: begin
        if (cnt == 4'd0) begin
          state_next = cur.wr ? S_WRITE : S_READ;
          cnt_next   = PHASE_LOAD;
        end
      end
      S_WRITE: begin
        mode   = WRITE;
        PSG_DO = cur.data;
        if (cnt == 4'd0) begin
          state_next = S_GAP_D;
          cnt_next   = GAP_LOAD;
        end
      end
      S_READ: begin
        mode = READ;
        if (cnt == 4'd0) begin
          state_next = S_GAP_D;
          cnt_next   = GAP_LOAD;
        end
      end
      S_GAP_D: begin
        if (cnt == 4'd0) begin
          state_next = S_IDLE;
          cnt_next   = PHASE_LOAD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cur       <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 8'h00;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      RSP_VALID <= read_last;
      BUSY      <= (state_next != S_IDLE) || (fill_next != '0);
      if (pop)       cur      <= head;
      if (read_last) RSP_DATA <= PSG_DI;
    end
  end

endmodule

// File: tb/tb_psg_bus_master.sv
// tb/tb_psg_bus_master.sv - randomized self-checking bench for psg_bus_master with a YM2149 bus model
module tb_psg_bus_master;

  localparam int P0 = 2;
  localparam int G0 = 1;
  localparam int P1 = 1;
  localparam int G1 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      req_valid, req_ready, req_wr, rsp_valid, busy, bdir, bc;
  logic [1:0][3:0] req_addr;
  logic [1:0][7:0] req_data, rsp_data, psg_do, psg_di, ioa;

  psg_bus_master #(.PHASE_CYCLES(P0), .GAP_CYCLES(G0), .FIFO_DEPTH(4)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
    .REQ_WR(req_wr[0]), .REQ_ADDR(req_addr[0]), .REQ_DATA(req_data[0]),
    .RSP_VALID(rsp_valid[0]), .RSP_DATA(rsp_data[0]), .BUSY(busy[0]),
    .BDIR(bdir[0]), .BC(bc[0]), .PSG_DO(psg_do[0]), .PSG_DI(psg_di[0])
  );

  psg_bus_master #(.PHASE_CYCLES(P1), .GAP_CYCLES(G1), .FIFO_DEPTH(4)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
    .REQ_WR(req_wr[1]), .REQ_ADDR(req_addr[1]), .REQ_DATA(req_data[1]),
    .RSP_VALID(rsp_valid[1]), .RSP_DATA(rsp_data[1]), .BUSY(busy[1]),
    .BDIR(bdir[1]), .BC(bc[1]), .PSG_DO(psg_do[1]), .PSG_DI(psg_di[1])
  );

  // YM2149 bus model: latch on BDIR=1/BC=1, write on BDIR=1/BC=0, drive data on BDIR=0/BC=1
  logic [7:0] ymreg [2][16];
  logic [3:0] lat [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int r = 0; r < 16; r++) ymreg[d][r] <= 8'h00;
      end else if (bdir[d] && bc[d]) begin
        lat[d] <= psg_do[d][3:0];
      end else if (bdir[d] && !bc[d]) begin
        ymreg[d][lat[d]] <= psg_do[d];
      end
    end
  end

  always_comb begin
    psg_di = '0;
    for (int d = 0; d < 2; d++) begin
      if (!bdir[d] && bc[d])
        psg_di[d] = (lat[d] == 4'd14 && !ymreg[d][7][6]) ? ioa[d] : ymreg[d][lat[d]];
    end
  end

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } req_s;

  req_s        reqs[$];
  logic [11:0] exp_tr[$], act_tr[$];
  logic [7:0]  exp_rd[$], act_rd[$];
  logic [7:0]  ref_regs [2][16];
  logic        ref_cv [2];
  logic [3:0]  ref_ca [2];
  int          errors = 0;
  int          checks = 0;

  task automatic clear_ref();
    for (int d = 0; d < 2; d++) begin
      ref_cv[d] = 1'b0;
      ref_ca[d] = 4'h0;
      for (int r = 0; r < 16; r++) ref_regs[d][r] = 8'h00;
    end
  endtask

  function automatic logic [11:0] ent(input logic [1:0] bus, input logic [7:0] dout, input logic rv);
    return {bus, dout, rv, 1'b1};
  endfunction

  // per-clock expectation {bdir,bc,do,rsp_valid,busy} from the request list and bus rules
  task automatic build_expected(input int d, input int p, input int g);
    logic        hit;
    logic [7:0]  rv;
    logic [11:0] last;
    exp_tr.delete();
    exp_rd.delete();
    exp_tr.push_back(ent(2'b00, 8'hFF, 1'b0));
    exp_rd.push_back(8'h00);
    foreach (reqs[i]) begin
      hit = 1'b0;
`ifdef PSG_BUS_ADDR_CACHE_EN
      hit = ref_cv[d] && (ref_ca[d] == reqs[i].addr);
`endif
      if (!hit) begin
        for (int k = 0; k < p; k++) begin
          exp_tr.push_back(ent(2'b11, {4'h0, reqs[i].addr}, 1'b0)); exp_rd.push_back(8'h00);
        end
        for (int k = 0; k < g; k++) begin
          exp_tr.push_back(ent(2'b00, 8'hFF, 1'b0)); exp_rd.push_back(8'h00);
        end
        ref_cv[d] = 1'b1;
        ref_ca[d] = reqs[i].addr;
      end
      rv = (reqs[i].addr == 4'd14 && !ref_regs[d][7][6]) ? ioa[d] : ref_regs[d][reqs[i].addr];
      if (reqs[i].wr) ref_regs[d][reqs[i].addr] = reqs[i].data;
      for (int k = 0; k < p; k++) begin
        exp_tr.push_back(reqs[i].wr ? ent(2'b10, reqs[i].data, 1'b0) : ent(2'b01, 8'hFF, 1'b0));
        exp_rd.push_back(8'h00);
      end
      for (int k = 0; k < g; k++) begin
        exp_tr.push_back(ent(2'b00, 8'hFF, (k == 0) && !reqs[i].wr));
        exp_rd.push_back(rv);
      end
      exp_tr.push_back(ent(2'b00, 8'hFF, 1'b0));
      exp_rd.push_back(8'h00);
    end
    last = exp_tr.pop_back();
    last[0] = 1'b0;
    exp_tr.push_back(last);
  endtask

  task automatic push_all(input int d);
    int n;
    foreach (reqs[i]) begin
      req_valid[d] = 1'b1;
      req_wr[d]    = reqs[i].wr;
      req_addr[d]  = reqs[i].addr;
      req_data[d]  = reqs[i].data;
      n = 0;
      while (!req_ready[d] && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (!req_ready[d]) begin
        errors++;
        $display("FAIL push_timeout dut%0d req %0d: ready=%b, want 1", d, i, req_ready[d]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic capture(input int d, input int n);
    act_tr.delete();
    act_rd.delete();
    repeat (n) begin
      @(negedge clk);
      act_tr.push_back({bdir[d], bc[d], psg_do[d], rsp_valid[d], busy[d]});
      act_rd.push_back(rsp_data[d]);
    end
  endtask

  task automatic run_batch(input int d);
    fork
      push_all(d);
      capture(d, exp_tr.size());
    join
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0; ioa = '0;
    clear_ref();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({bdir[d], bc[d], psg_do[d], rsp_valid[d], rsp_data[d], busy[d], req_ready[d]} !== {2'b00, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset_values dut%0d: bdir=%b bc=%b do=%h rv=%b rd=%h busy=%b ready=%b, want 0 0 ff 0 00 0 1",
                 d, bdir[d], bc[d], psg_do[d], rsp_valid[d], rsp_data[d], busy[d], req_ready[d]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    reqs.delete();
    reqs.push_back('{wr: 1'b1, addr: 4'd7, data: 8'h38});
    build_expected(0, P0, G0);
    run_batch(0);
    foreach (exp_tr[i]) begin
      checks++;
      if (act_tr[i] !== exp_tr[i] || (exp_tr[i][1] && act_rd[i] !== exp_rd[i])) begin
        errors++;
        $display("FAIL write_trace cyc %0d: got %h rd %h, want %h rd %h", i, act_tr[i], act_rd[i], exp_tr[i], exp_rd[i]);
      end
    end
    checks++;
    if (ymreg[0][7] !== 8'h38) begin
      errors++;
      $display("FAIL write_ymreg7: got %h, want 38", ymreg[0][7]);
    end
  endtask

  task automatic test_read();
    ioa[0] = 8'hA5;
    reqs.delete();
    reqs.push_back('{wr: 1'b0, addr: 4'd14, data: 8'($urandom)});
    build_expected(0, P0, G0);
    run_batch(0);
    foreach (exp_tr[i]) begin
      checks++;
      if (act_tr[i] !== exp_tr[i] || (exp_tr[i][1] && act_rd[i] !== exp_rd[i])) begin
        errors++;
        $display("FAIL read_trace cyc %0d: got %h rd %h, want %h rd %h", i, act_tr[i], act_rd[i], exp_tr[i], exp_rd[i]);
      end
    end
    checks++;
    if (act_tr[1 + 5][1] !== 1'b1 || act_rd[1 + 5] !== 8'hA5) begin
      errors++;
      $display("FAIL read_rsp_at_5: rv=%b rd=%h, want 1 a5", act_tr[6][1], act_rd[6]);
    end
  endtask

  task automatic test_fifo_full();
    reqs.delete();
    for (int i = 0; i < 5; i++) reqs.push_back('{wr: 1'b1, addr: 4'($urandom_range(0, 13)), data: 8'($urandom)});
    build_expected(0, P0, G0);
    fork
      run_batch(0);
      begin
        repeat (4) @(negedge clk);
        checks++;
        if (req_ready[0] !== 1'b1) begin
          errors++;
          $display("FAIL fifo_ready_at3: got %b, want 1", req_ready[0]);
        end
        @(negedge clk);
        checks++;
        if (req_ready[0] !== 1'b0) begin
          errors++;
          $display("FAIL fifo_ready_full: got %b, want 0", req_ready[0]);
        end
      end
    join
    foreach (exp_tr[i]) begin
      checks++;
      if (act_tr[i] !== exp_tr[i] || (exp_tr[i][1] && act_rd[i] !== exp_rd[i])) begin
        errors++;
        $display("FAIL fifo_trace cyc %0d: got %h rd %h, want %h rd %h", i, act_tr[i], act_rd[i], exp_tr[i], exp_rd[i]);
      end
    end
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (ymreg[0][r] !== ref_regs[0][r]) begin
        errors++;
        $display("FAIL fifo_ymreg[%0d]: got %h, want %h", r, ymreg[0][r], ref_regs[0][r]);
      end
    end
  endtask

  task automatic test_addr_cache();
    reqs.delete();
    reqs.push_back('{wr: 1'b1, addr: 4'd13, data: 8'($urandom)});
    reqs.push_back('{wr: 1'b1, addr: 4'd13, data: 8'($urandom)});
    build_expected(0, P0, G0);
    run_batch(0);
    foreach (exp_tr[i]) begin
      checks++;
      if (act_tr[i] !== exp_tr[i] || (exp_tr[i][1] && act_rd[i] !== exp_rd[i])) begin
        errors++;
        $display("FAIL cache_trace cyc %0d: got %h rd %h, want %h rd %h", i, act_tr[i], act_rd[i], exp_tr[i], exp_rd[i]);
      end
    end
  endtask

  task automatic test_param_sweep();
    ioa[1] = 8'($urandom);
    reqs.delete();
    reqs.push_back('{wr: 1'b0, addr: 4'd14, data: 8'h00});
    reqs.push_back('{wr: 1'b1, addr: 4'($urandom_range(0, 13)), data: 8'($urandom)});
    build_expected(1, P1, G1);
    run_batch(1);
    foreach (exp_tr[i]) begin
      checks++;
      if (act_tr[i] !== exp_tr[i] || (exp_tr[i][1] && act_rd[i] !== exp_rd[i])) begin
        errors++;
        $display("FAIL sweep_trace cyc %0d: got %h rd %h, want %h rd %h", i, act_tr[i], act_rd[i], exp_tr[i], exp_rd[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int  n;
    logic seen;
    reqs.delete();
    for (int i = 0; i < 3; i++) reqs.push_back('{wr: 1'b1, addr: 4'(i + 3), data: 8'($urandom)});
    fork
      push_all(0);
      begin
        n = 0;
        @(negedge clk);
        while (!(bdir[0] && !bc[0]) && n < 50) begin
          @(negedge clk);
          n++;
        end
      end
    join
    checks++;
    if (!(bdir[0] && !bc[0])) begin
      errors++;
      $display("FAIL arst_reach_write: bdir=%b bc=%b, want 1 0", bdir[0], bc[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bdir[0], bc[0], psg_do[0], busy[0], req_ready[0]} !== {2'b00, 8'hFF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL arst_immediate: bdir=%b bc=%b do=%h busy=%b ready=%b, want 0 0 ff 0 1",
               bdir[0], bc[0], psg_do[0], busy[0], req_ready[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_ref();
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bdir[0] || bc[0] || busy[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL arst_no_replay: bus or busy active after reset=%b, want 0", seen);
    end
  endtask

  task automatic test_random();
    ioa[0] = 8'($urandom);
    reqs.delete();
    for (int i = 0; i < 16; i++)
      reqs.push_back('{wr: 1'($urandom_range(0, 1)), addr: 4'($urandom_range(0, 15)), data: 8'($urandom)});
    build_expected(0, P0, G0);
    run_batch(0);
    foreach (exp_tr[i]) begin
      checks++;
      if (act_tr[i] !== exp_tr[i] || (exp_tr[i][1] && act_rd[i] !== exp_rd[i])) begin
        errors++;
        $display("FAIL random_trace cyc %0d: got %h rd %h, want %h rd %h", i, act_tr[i], act_rd[i], exp_tr[i], exp_rd[i]);
      end
    end
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (ymreg[0][r] !== ref_regs[0][r]) begin
        errors++;
        $display("FAIL random_ymreg[%0d]: got %h, want %h", r, ymreg[0][r], ref_regs[0][r]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_addr_cache();
    test_param_sweep();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
